data_memory_sync: RTL and testbench

- Parametrised, clocked successor to the CPU's combinational data memory.
- Byte-addressed, word-organised RAM serving the load/store stage.
- Supports byte, halfword and word accesses with sign or zero extension, plus alignment and range error reporting.
- Request/response valid-ready handshake, one request in flight, response held under backpressure.

---
 rtl/mem_pkg.sv | 32 +++
 rtl/mem_lane_align.sv | 69 ++++++
 rtl/data_memory_sync.sv | 160 ++++++++++++++++
 tb/tb_data_memory_sync.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the load/store memory path: size encodings,
// byte-enable mapping and the preload image used at elaboration.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    localparam int          PRELOAD_N    = 10;
    localparam logic [31:0] PRELOAD_BASE = 32'hA000_00AA;
    localparam logic [31:0] PRELOAD_STEP = 32'h1000_0011;

    function automatic logic [31:0] preload_word(input int n);
        logic [31:0] nn;
        nn = 32'(n);
        return (n == 0) ? PRELOAD_BASE : nn * PRELOAD_STEP;
    endfunction

    // Lanes touched by an access within the 32-bit addressed word.
    function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] lane);
        logic [3:0] m;
        case (size)
            SZ_BYTE: m = 4'b0001 << lane;
            SZ_HALF: m = 4'b0011 << {lane[1], 1'b0};
            SZ_WORD: m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: store byte enables / replicated write word,
// and load extraction with sign or zero extension.
module mem_lane_align
    import mem_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [1:0]          st_size,
    input  logic [1:0]          st_lane,
    input  logic [DATA_W-1:0]   st_wdata,
    output logic [DATA_W/8-1:0] st_be,
    output logic [DATA_W-1:0]   st_wword,
    input  logic [1:0]          ld_size,
    input  logic [1:0]          ld_lane,
    input  logic                ld_unsigned,
    input  logic [DATA_W-1:0]   ld_word,
    output logic [DATA_W-1:0]   ld_data
);

    localparam int NB = DATA_W / 8;

    logic [3:0]  mask;
    logic [31:0] shifted;
    logic        sign;

    assign mask = byte_mask(st_size, st_lane);

    // Accesses live in the low 32 bits of a word; wider words keep upper lanes idle.
    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_lane
            if (gi < 4) begin : g_active
                assign st_be[gi] = mask[gi];
                assign st_wword[gi*8 +: 8] =
                    (st_size == SZ_BYTE) ? st_wdata[7:0] :
                    (st_size == SZ_HALF) ? st_wdata[(gi % 2)*8 +: 8] :
                                           st_wdata[gi*8 +: 8];
            end else begin : g_idle
                assign st_be[gi]           = 1'b0;
                assign st_wword[gi*8 +: 8] = 8'h00;
            end
        end
    endgenerate

    assign shifted = ld_word[31:0] >> {ld_lane, 3'b000};

    always_comb begin
        sign    = 1'b0;
        ld_data = '0;
        case (ld_size)
            SZ_BYTE: begin
                sign          = !ld_unsigned && shifted[7];
                ld_data       = {DATA_W{sign}};
                ld_data[7:0]  = shifted[7:0];
            end
            SZ_HALF: begin
                sign          = !ld_unsigned && shifted[15];
                ld_data       = {DATA_W{sign}};
                ld_data[15:0] = shifted[15:0];
            end
            SZ_WORD: begin
                sign          = !ld_unsigned && shifted[31];
                ld_data       = {DATA_W{sign}};
                ld_data[31:0] = shifted;
            end
            default: ld_data = '0;
        endcase
    end

endmodule

// File: rtl/data_memory_sync.sv
// Clocked byte-addressed data memory with valid/ready request and response,
// one request in flight, 1-cycle load latency and error reporting.
module data_memory_sync
    import mem_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 256,
    parameter int ADDR_W  = 32,
    parameter int INIT_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err
);

    localparam int IW     = $clog2(DEPTH);
    localparam int NB     = DATA_W / 8;
    localparam int IDX_HI = IW + 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    typedef logic [DATA_W-1:0] mem_t [DEPTH];

    function automatic mem_t init_image();
        mem_t img;
        for (int i = 0; i < DEPTH; i++) begin
            img[i] = '0;
        end
        if (INIT_EN == 1) begin
            for (int n = 0; n < PRELOAD_N; n++) begin
                if (n < DEPTH) begin
                    img[n] = DATA_W'(preload_word(n));
                end
            end
        end
        return img;
    endfunction

    mem_t mem = init_image();

    logic [0:0]        state_reg, state_next;
    logic [DATA_W-1:0] rword_reg;
    logic [1:0]        size_reg;
    logic [1:0]        lane_reg;
    logic              uns_reg;
    logic              err_reg;
    logic              load_ok_reg;

    logic              accept;
    logic [IW-1:0]     idx;
    logic [1:0]        lane;
    logic              range_err;
    logic              align_err;
    logic              req_err;
    logic [NB-1:0]     be;
    logic [DATA_W-1:0] wword;
    logic [DATA_W-1:0] ld_data;

    assign resp_valid = (state_reg == ST_BUSY);
    assign req_ready  = !resp_valid || resp_ready;
    assign accept     = req_valid && req_ready;
    assign idx        = req_addr[IDX_HI:2];
    assign lane       = req_addr[1:0];

    generate
        if (ADDR_W > IDX_HI + 1) begin : g_range
            assign range_err = |req_addr[ADDR_W-1:IDX_HI+1];
        end else begin : g_norange
            assign range_err = 1'b0;
        end
    endgenerate

    always_comb begin
        align_err = 1'b0;
        case (req_size)
            SZ_BYTE: align_err = 1'b0;
            SZ_HALF: align_err = lane[0];
            SZ_WORD: align_err = (lane != 2'b00);
            default: align_err = 1'b1;
        endcase
    end

    assign req_err = align_err || range_err;

    mem_lane_align #(
        .DATA_W (DATA_W)
    ) u_align (
        .st_size     (req_size),
        .st_lane     (lane),
        .st_wdata    (req_wdata),
        .st_be       (be),
        .st_wword    (wword),
        .ld_size     (size_reg),
        .ld_lane     (lane_reg),
        .ld_unsigned (uns_reg),
        .ld_word     (rword_reg),
        .ld_data     (ld_data)
    );

    // RAM port: byte-enabled write and registered read; reset blocks commits.
    always_ff @(posedge clk) begin
        if (accept && req_we && !req_err && !rst) begin
            for (int b = 0; b < NB; b++) begin
                if (be[b]) begin
                    mem[idx][b*8 +: 8] <= wword[b*8 +: 8];
                end
            end
        end
        if (accept && !req_we) begin
            rword_reg <= mem[idx];
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (accept) state_next = ST_BUSY;
            ST_BUSY: if (resp_ready && !accept) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            size_reg    <= SZ_BYTE;
            lane_reg    <= 2'b00;
            uns_reg     <= 1'b0;
            err_reg     <= 1'b0;
            load_ok_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                size_reg    <= req_size;
                lane_reg    <= lane;
                uns_reg     <= req_unsigned;
                err_reg     <= req_err;
                load_ok_reg <= !req_we && !req_err;
            end else if (resp_ready) begin
                err_reg     <= 1'b0;
                load_ok_reg <= 1'b0;
            end
        end
    end

    assign resp_err   = err_reg;
    assign resp_rdata = load_ok_reg ? ld_data : '0;

endmodule

// File: tb/tb_data_memory_sync.sv
// Directed scoreboard bench for data_memory_sync: expectations queued at
// request time and checked when each response is consumed.
module tb_data_memory_sync;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    data_memory_sync #(
        .DATA_W  (32),
        .DEPTH   (256),
        .ADDR_W  (32),
        .INIT_EN (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the request was accepted.
    task automatic send(input string tag, input logic we, input logic [31:0] addr,
                        input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input logic exp_err);
        exp_t e;
        bit   ok;
        req_valid    = 1'b1;
        req_we       = we;
        req_addr     = addr;
        req_size     = size;
        req_unsigned = uns;
        req_wdata    = wdata;
        e.rdata = exp_rd;
        e.err   = exp_err;
        e.tag   = tag;
        sb.push_back(e);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk({tag, "_accept"}, 32'(ok), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        $display("req %s we=%0b addr=%h size=%0d uns=%0b wdata=%h", tag, we, addr, size, uns, wdata);
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
        #1;
        chk("drain", 32'(sb.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        if (!rst && resp_valid && resp_ready) begin
            if (sb.size() == 0) begin
                chk("resp_expected", 32'd0, 32'd1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk(e.tag, resp_rdata, e.rdata);
                chk({e.tag, "_err"}, 32'(resp_err), 32'(e.err));
                $display("resp %s rdata=%h err=%0b", e.tag, resp_rdata, resp_err);
            end
        end
    end

    initial begin
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_addr     = '0;
        req_size     = 2'b10;
        req_unsigned = 1'b0;
        req_wdata    = '0;
        resp_ready   = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(resp_valid), 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_err", 32'(resp_err), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;

        send("ldw_04", 1'b0, 32'h04, 2'b10, 1'b0, 32'h0, 32'h1000_0011, 1'b0);
        @(negedge clk);
        chk("latency1_valid", 32'(resp_valid), 32'd1);
        drain();

        send("stb_01",   1'b1, 32'h01, 2'b00, 1'b0, 32'h0000_00EE, 32'h0, 1'b0);
        send("ldw_00",   1'b0, 32'h00, 2'b10, 1'b0, 32'h0, 32'hA000_EEAA, 1'b0);
        send("ldb_01s",  1'b0, 32'h01, 2'b00, 1'b0, 32'h0, 32'hFFFF_FFEE, 1'b0);
        send("ldb_01u",  1'b0, 32'h01, 2'b00, 1'b1, 32'h0, 32'h0000_00EE, 1'b0);
        send("sth_0a",   1'b1, 32'h0A, 2'b01, 1'b0, 32'h0000_8001, 32'h0, 1'b0);
        send("ldh_0as",  1'b0, 32'h0A, 2'b01, 1'b0, 32'h0, 32'hFFFF_8001, 1'b0);
        send("ldw_08",   1'b0, 32'h08, 2'b10, 1'b0, 32'h0, 32'h8001_0022, 1'b0);
        send("ldh_0au",  1'b0, 32'h0A, 2'b01, 1'b1, 32'h0, 32'h0000_8001, 1'b0);
        send("stw_0c",   1'b1, 32'h0C, 2'b10, 1'b0, 32'hCAFE_F00D, 32'h0, 1'b0);
        send("ldw_0c",   1'b0, 32'h0C, 2'b10, 1'b0, 32'h0, 32'hCAFE_F00D, 1'b0);
        send("ldb_0fs",  1'b0, 32'h0F, 2'b00, 1'b0, 32'h0, 32'hFFFF_FFCA, 1'b0);
        send("ldh_0eu",  1'b0, 32'h0E, 2'b01, 1'b1, 32'h0, 32'h0000_CAFE, 1'b0);
        send("stb_13",   1'b1, 32'h13, 2'b00, 1'b0, 32'hFFFF_FF7F, 32'h0, 1'b0);
        send("ldw_10",   1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 32'h7F00_0044, 1'b0);

        send("err_ldw_06",  1'b0, 32'h06,  2'b10, 1'b0, 32'h0, 32'h0, 1'b1);
        send("err_stw_400", 1'b1, 32'h400, 2'b10, 1'b0, 32'hDEAD_BEEF, 32'h0, 1'b1);
        send("err_ld_rsvd", 1'b0, 32'h00,  2'b11, 1'b0, 32'h0, 32'h0, 1'b1);
        send("err_st_rsvd", 1'b1, 32'h04,  2'b11, 1'b0, 32'hDEAD_BEEF, 32'h0, 1'b1);
        send("err_sth_05",  1'b1, 32'h05,  2'b01, 1'b0, 32'hBEEF, 32'h0, 1'b1);
        send("post_ldw_04", 1'b0, 32'h04,  2'b10, 1'b0, 32'h0, 32'h1000_0011, 1'b0);
        send("post_ldw_00", 1'b0, 32'h00,  2'b10, 1'b0, 32'h0, 32'hA000_EEAA, 1'b0);
        drain();

        // Backpressure: hold the response for several cycles, then stream.
        resp_ready = 1'b0;
        send("bp_ldw_04", 1'b0, 32'h04, 2'b10, 1'b0, 32'h0, 32'h1000_0011, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(resp_valid), 32'd1);
            chk("bp_rdata", resp_rdata, 32'h1000_0011);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        resp_ready = 1'b1;
        send("bp_ldw_08", 1'b0, 32'h08, 2'b10, 1'b0, 32'h0, 32'h8001_0022, 1'b0);
        @(negedge clk);
        chk("no_bubble_valid", 32'(resp_valid), 32'd1);
        drain();

        // Reset mid-operation with a pending load and a store in the reset cycle.
        resp_ready   = 1'b0;
        req_valid    = 1'b1;
        req_we       = 1'b0;
        req_addr     = 32'h04;
        req_size     = 2'b10;
        @(posedge clk);
        #1;
        rst          = 1'b1;
        resp_ready   = 1'b1;
        req_valid    = 1'b1;
        req_we       = 1'b1;
        req_addr     = 32'h20;
        req_size     = 2'b10;
        req_wdata    = 32'h1234_5678;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        chk("rst_mid_valid", 32'(resp_valid), 32'd0);
        @(posedge clk);
        #1;
        send("ldw_20", 1'b0, 32'h20, 2'b10, 1'b0, 32'h0, 32'h8000_0088, 1'b0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
